// File: rtl/seq_ctrl.sv
// seq_ctrl: instruction fetch/decode/execute sequencer with fetch timeout and retirement counter
// Ports:
//   clk        rising-edge system clock
//   rst        asynchronous active-low reset
//   run        front-panel run level; 0 stops at the next instruction boundary
//   mem_ack    memory read-data-valid for the current fetch
//   ir_op      4-bit opcode, valid with mem_ack and held in the IR afterwards
//   zf         ALU zero flag, used by JZ in DECODE
//   mem_rd     memory read request (FETCH and WAIT only)
//   IRload     IR load strobe, combinational from mem_ack in WAIT
//   PCinc      PC increment strobe, combinational from mem_ack in WAIT
//   PCload     PC parallel-load strobe (BRANCH)
//   alu_en     ALU execute strobe for opcodes 0x1-0x7
//   halted     high while in HALT
//   err        sticky fetch-timeout flag, cleared only by reset
//   state      current state encoding
//   instr_cnt  retired-instruction counter, wraps modulo 2^16
module seq_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        mem_ack,
    input  logic [3:0]  ir_op,
    input  logic        zf,
    output logic        mem_rd,
    output logic        IRload,
    output logic        PCinc,
    output logic        PCload,
    output logic        alu_en,
    output logic        halted,
    output logic        err,
    output logic [2:0]  state,
    output logic [15:0] instr_cnt
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        DECODE = 3'd3,
        EXEC   = 3'd4,
        BRANCH = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t     st, nxt;
    logic [3:0] tmo;
    logic       retire, tmo_hit;

    assign state = st;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st        <= IDLE;
            tmo       <= 4'd0;
            err       <= 1'b0;
            instr_cnt <= 16'd0;
        end else begin
            st        <= nxt;
            tmo       <= (st == FETCH) ? 4'd0 : (st == WAIT && !mem_ack) ? tmo + 4'd1 : tmo;
            err       <= err | tmo_hit;
            instr_cnt <= instr_cnt + {15'd0, retire};
        end
    end

    // Strobes are decoded from the registered state only (plus mem_ack in WAIT),
    // so an asynchronous reset drops them together with the state.
    always_comb begin
        nxt     = IDLE;
        mem_rd  = 1'b0;
        IRload  = 1'b0;
        PCinc   = 1'b0;
        PCload  = 1'b0;
        alu_en  = 1'b0;
        halted  = 1'b0;
        retire  = 1'b0;
        tmo_hit = 1'b0;
        case (st)
            IDLE:   nxt = run ? FETCH : IDLE;
            FETCH: begin
                mem_rd = 1'b1;
                nxt    = WAIT;
            end
            WAIT: begin
                mem_rd  = 1'b1;
                IRload  = mem_ack;
                PCinc   = mem_ack;
                tmo_hit = !mem_ack && tmo == 4'hF;
                nxt     = mem_ack ? DECODE : tmo_hit ? HALT : WAIT;
            end
            DECODE: begin
                // Untaken JZ and HLT retire straight out of DECODE.
                retire = (ir_op == 4'h9 && !zf) || ir_op == 4'hF;
                nxt    = (ir_op == 4'hF) ? HALT :
                         (ir_op == 4'h8 || (ir_op == 4'h9 && zf)) ? BRANCH :
                         (ir_op == 4'h9) ? (run ? FETCH : IDLE) : EXEC;
            end
            EXEC: begin
                alu_en = ir_op != 4'h0 && !ir_op[3];
                retire = 1'b1;
                nxt    = run ? FETCH : IDLE;
            end
            BRANCH: begin
                PCload = 1'b1;
                retire = 1'b1;
                nxt    = run ? FETCH : IDLE;
            end
            HALT: begin
                halted = 1'b1;
                nxt    = run ? HALT : IDLE;
            end
            default: nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_seq_ctrl.sv
// tb_seq_ctrl: directed self-checking bench for seq_ctrl
module tb_seq_ctrl;
    logic        clk, rst, run, mem_ack, zf;
    logic [3:0]  ir_op;
    logic        mem_rd, IRload, PCinc, PCload, alu_en, halted, err;
    logic [2:0]  state;
    logic [15:0] instr_cnt;
    int          n_chk = 0;
    int          n_fail = 0;

    seq_ctrl dut (
        .clk(clk), .rst(rst), .run(run), .mem_ack(mem_ack), .ir_op(ir_op), .zf(zf),
        .mem_rd(mem_rd), .IRload(IRload), .PCinc(PCinc), .PCload(PCload),
        .alu_en(alu_en), .halted(halted), .err(err), .state(state), .instr_cnt(instr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {state, mem_rd, IRload, PCinc, PCload, alu_en, halted, err}
    localparam logic [9:0] S_IDLE   = {3'd0, 7'b0000000};
    localparam logic [9:0] S_IDLE_E = {3'd0, 7'b0000001};
    localparam logic [9:0] S_FETCH  = {3'd1, 7'b1000000};
    localparam logic [9:0] S_FETCH_E= {3'd1, 7'b1000001};
    localparam logic [9:0] S_WACK   = {3'd2, 7'b1110000};
    localparam logic [9:0] S_WAIT   = {3'd2, 7'b1000000};
    localparam logic [9:0] S_WAIT_E = {3'd2, 7'b1000001};
    localparam logic [9:0] S_DEC    = {3'd3, 7'b0000000};
    localparam logic [9:0] S_ALU    = {3'd4, 7'b0000100};
    localparam logic [9:0] S_NOP    = {3'd4, 7'b0000000};
    localparam logic [9:0] S_BR     = {3'd5, 7'b0001000};
    localparam logic [9:0] S_HALT   = {3'd6, 7'b0000010};
    localparam logic [9:0] S_HALT_E = {3'd6, 7'b0000011};

    function automatic logic [9:0] outs();
        return {state, mem_rd, IRload, PCinc, PCload, alu_en, halted, err};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [9:0] exp);
        @(negedge clk);
        chk(tag, {6'd0, outs()}, {6'd0, exp});
    endtask

    initial begin
        rst = 1'b0; run = 1'b0; mem_ack = 1'b0; ir_op = 4'h0; zf = 1'b0;
        @(negedge clk);
        chk("reset_outs", {6'd0, outs()}, {6'd0, S_IDLE});
        chk("reset_cnt", instr_cnt, 16'h0000);
        rst = 1'b1;
        step("idle_hold", S_IDLE);

        // ALU op 0x3: 1,2,3,4,1
        run = 1'b1; mem_ack = 1'b1; ir_op = 4'h3;
        step("alu_fetch", S_FETCH);
        step("alu_wait", S_WACK);
        step("alu_decode", S_DEC);
        step("alu_exec", S_ALU);
        step("alu_refetch", S_FETCH);
        chk("alu_cnt", instr_cnt, 16'd1);

        // JZ taken
        ir_op = 4'h9; zf = 1'b1;
        step("jzt_wait", S_WACK);
        step("jzt_decode", S_DEC);
        step("jzt_branch", S_BR);
        step("jzt_refetch", S_FETCH);
        chk("jzt_cnt", instr_cnt, 16'd2);

        // JZ untaken: 3-cycle loop
        zf = 1'b0;
        step("jzn_wait", S_WACK);
        step("jzn_decode", S_DEC);
        step("jzn_refetch", S_FETCH);
        chk("jzn_cnt", instr_cnt, 16'd3);

        // NOP, run dropped during EXEC
        ir_op = 4'h0;
        step("nop_wait", S_WACK);
        step("nop_decode", S_DEC);
        step("nop_exec", S_NOP);
        run = 1'b0;
        step("stop_idle", S_IDLE);
        chk("stop_cnt", instr_cnt, 16'd4);
        step("stop_no_rd", S_IDLE);

        // Undefined opcode behaves as NOP
        run = 1'b1; ir_op = 4'hB;
        step("undef_fetch", S_FETCH);
        step("undef_wait", S_WACK);
        step("undef_decode", S_DEC);
        step("undef_exec", S_NOP);
        step("undef_refetch", S_FETCH);
        chk("undef_cnt", instr_cnt, 16'd5);

        // HLT
        ir_op = 4'hF;
        step("hlt_wait", S_WACK);
        step("hlt_decode", S_DEC);
        step("hlt_halt", S_HALT);
        chk("hlt_cnt", instr_cnt, 16'd6);
        step("hlt_hold", S_HALT);
        run = 1'b0;
        step("hlt_idle", S_IDLE);
        chk("hlt_cnt_after", instr_cnt, 16'd6);

        // Fetch timeout: 16 WAIT cycles then HALT with err
        run = 1'b1; mem_ack = 1'b0; ir_op = 4'h0;
        step("to_fetch", S_FETCH);
        for (int i = 0; i < 16; i++) step($sformatf("to_wait%0d", i), S_WAIT);
        step("to_halt", S_HALT_E);
        step("to_halt_hold", S_HALT_E);
        run = 1'b0;
        step("to_idle_err", S_IDLE_E);
        chk("to_cnt", instr_cnt, 16'd6);

        // Reset mid-WAIT with IRload active, no clock edge
        run = 1'b1;
        step("rw_fetch", S_FETCH_E);
        step("rw_wait", S_WAIT_E);
        mem_ack = 1'b1;
        #1;
        chk("rw_ack", {6'd0, outs()}, {6'd0, 3'd2, 7'b1110001});
        #1 rst = 1'b0;
        #1;
        chk("rw_reset_outs", {6'd0, outs()}, {6'd0, S_IDLE});
        chk("rw_reset_cnt", instr_cnt, 16'h0000);
        run = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step("rw_idle", S_IDLE);

        // Counter wrap
        force dut.instr_cnt = 16'hFFFF;
        #1 release dut.instr_cnt;
        #1;
        chk("wrap_preload", instr_cnt, 16'hFFFF);
        run = 1'b1; ir_op = 4'h0;
        step("wrap_fetch", S_FETCH);
        step("wrap_wait", S_WACK);
        step("wrap_decode", S_DEC);
        step("wrap_exec", S_NOP);
        chk("wrap_before", instr_cnt, 16'hFFFF);
        step("wrap_refetch", S_FETCH);
        chk("wrap_cnt", instr_cnt, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-002 rst  input  1  asynchronous, active-low reset; 0 forces reset state immediately, 1 is normal operation.
REQ-003 run  input  1  level enable from the front panel; 1 = execute program, 0 = stop at the next instruction boundary.
REQ-004 mem_ack  input  1  memory read-data-valid strobe for the current fetch.
REQ-005 ir_op  input  4  opcode field of the instruction on the bus, valid while mem_ack = 1 and held in the IR afterwards.
REQ-006 zf  input  1  ALU zero flag, sampled in DECODE.
REQ-007 mem_rd  output  1  memory read request.
REQ-008 IRload  output  1  instruction register load strobe.
REQ-009 PCinc  output  1  program-counter increment strobe.
REQ-010 PCload  output  1  program-counter parallel-load strobe; the PC takes its target from the bus.
REQ-011 alu_en  output  1  ALU execute strobe.
REQ-012 halted  output  1  1 while in HALT.
REQ-013 err  output  1  sticky fetch-timeout flag.
REQ-014 state  output  3  current state encoding, for debug.
REQ-015 instr_cnt  output  16  retired-instruction counter.

Function
REQ-016 States SHALL be encoded as IDLE=0, FETCH=1, WAIT=2, DECODE=3, EXEC=4, BRANCH=5, HALT=6; code 7 is illegal and SHALL go to IDLE on the next edge.
REQ-017 IDLE SHALL go to FETCH when run=1 and stay in IDLE when run=0.
REQ-018 FETCH SHALL assert mem_rd for exactly one cycle, clear the timeout counter and go to WAIT.
REQ-019 WAIT SHALL hold mem_rd=1; when mem_ack=1, IRload and PCinc SHALL be 1 in that same cycle (combinational from mem_ack) and the next state SHALL be DECODE.
REQ-020 WAIT SHALL increment a 4-bit timeout counter on each cycle with mem_ack=0; on the cycle the counter equals 15 with mem_ack=0, the block SHALL go to HALT and set err=1.
REQ-021 DECODE SHALL route on ir_op as follows:
  - 0x0-0x7 (NOP/ALU) -> EXEC
  - 0x8 (JMP) -> BRANCH
  - 0x9 (JZ) -> BRANCH if zf=1; if zf=0, the instruction retires and the block goes to FETCH if run=1, else IDLE
  - 0xF (HLT) -> HALT, and the instruction retires
  - 0xA-0xE -> treated as NOP, i.e. EXEC
REQ-022 EXEC SHALL assert alu_en for one cycle when ir_op is 0x1-0x7 and SHALL keep alu_en=0 for NOP and undefined opcodes.
REQ-023 BRANCH SHALL assert PCload for one cycle.
REQ-024 On leaving EXEC or BRANCH, the instruction retires; the next state SHALL be FETCH if run=1, else IDLE.
REQ-025 instr_cnt SHALL increment by 1 on every retirement, modulo 2^16, so 0xFFFF wraps to 0x0000.
REQ-026 HALT SHALL hold halted=1 with all strobes at 0, and SHALL go to IDLE only after run has been observed 0.
REQ-027 err SHALL be cleared only by reset.
REQ-028 PCinc and PCload SHALL never be 1 in the same cycle.
REQ-029 mem_rd SHALL be 0 in every state other than FETCH and WAIT.
REQ-030 Latency SHALL be as follows, for mem_ack on the first WAIT cycle:
  - ALU/NOP instruction: FETCH->FETCH = 4 cycles
  - taken branch: 4 cycles
  - untaken JZ: 3 cycles
REQ-031 A change of run to 0 mid-instruction SHALL NOT abort the instruction; it takes effect only at retirement.

Reset
REQ-032 While rst=0, the block SHALL be in IDLE with mem_rd, IRload, PCinc, PCload, alu_en, halted and err all 0, the timeout counter at 0 and instr_cnt at 0x0000.
REQ-033 Reset asserted in any state, including mid-WAIT, SHALL abandon the operation immediately with no strobe glitch after rst falls.
REQ-034 On the first rising edge after rst=1, the block SHALL evaluate the IDLE transition.

Verification
REQ-035 The bench SHALL cover fetch and ALU execution: run=1, mem_ack on the first WAIT cycle, ir_op=0x3 -> state sequence 1,2,3,4,1; PCinc and IRload pulse in WAIT; alu_en pulses once; instr_cnt=1.
REQ-036 The bench SHALL cover conditional branches: ir_op=0x9 with zf=1 -> BRANCH with one PCload pulse; ir_op=0x9 with zf=0 -> DECODE then FETCH with no PCload; instr_cnt increments by 1 in each case.
REQ-037 The bench SHALL cover fetch timeout: mem_ack held 0 -> after 16 WAIT cycles, state=6, err=1, halted=1; run 1->0 -> IDLE with err still 1.
REQ-038 The bench SHALL cover HLT and stop: ir_op=0xF -> HALT with instr_cnt incremented; run=0 asserted during EXEC -> EXEC completes, then IDLE, and no further mem_rd.
REQ-039 The bench SHALL cover reset mid-operation: rst=0 during WAIT -> all outputs 0 and state=0 without waiting for a clock edge.
REQ-040 The bench SHALL cover counter wrap: instr_cnt preloaded to 0xFFFF via 65535 NOP retirements (or forced), then one retirement -> 0x0000.
